serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial a+b+cin, LSB first, one bit per clock; result valid WIDTH cycles after accept.
// Single transaction in flight: in_ready drops until the result is taken; out_valid holds the result until out_ready.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;
    logic             half_s;
    logic             bit_s;
    logic             carry_nxt;
    logic             last_bit;
    logic [WIDTH:0]   sum_cat;

    // Two half-adder stages on the operand LSBs and the registered carry.
    always_comb begin
        half_s    = a_sh[0] ^ b_sh[0];
        bit_s     = half_s ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (half_s & carry);
        last_bit  = (bit_cnt == LAST_BIT);
        sum_cat   = {bit_s, sum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Each sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= cin;
                        bit_cnt <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry   <= carry_nxt;
                    sum     <= sum_cat[WIDTH:1];
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        cout <= carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
